spi_target: RTL and testbench
=============================

# spi_target

SPI target (responder) for the demo system's SPI bus. It answers an external SPI host driving SCK, CS_N and MOSI: it deserialises received bytes onto a valid/ready stream and serialises bytes supplied on a second valid/ready stream back on MISO. The bus is fixed at mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. All bus inputs are oversampled in the system clock domain; the block lives in the peripheral region of the system.

## Interface
- SyncStages, 2: flops in each input synchroniser on sck, cs_n and mosi; minimum 2.
- TxIdleByte, 8'hFF: byte shifted out when no TX data is held.

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_i  in  1  reset, asynchronous, active-high.
- spi_sck_i  in  1  bus clock from the host.
- spi_cs_ni  in  1  chip select, active low.
- spi_mosi_i  in  1  serial data from the host.
- spi_miso_o  out  1  serial data to the host.
- spi_miso_en_o  out  1  MISO output enable; high only while selected.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  rx_data_o valid; held until accepted.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX holding register empty.
- active_o  out  1  CS asserted (synchronised).
- rx_overrun_o  out  1  1-cycle pulse: a received byte was dropped.
- tx_underrun_o  out  1  1-cycle pulse: TxIdleByte loaded because the holding register was empty.
- abort_o  out  1  1-cycle pulse: CS deasserted mid-byte.

## Operation
- Input path: each bus input passes through a SyncStages-deep synchroniser, then one flop for edge detection. This produces events: sck_rise, sck_fall, cs_fall (select) and cs_rise (deselect).
- FSM states:
  - IDLE → ACTIVE on cs_fall.
  - ACTIVE → IDLE on cs_rise.
  - SCK events in IDLE are ignored.
  - If cs_rise and an SCK event occur in the same cycle, the cs_rise wins and the SCK event is ignored.
- TX holding register (1 entry):
  - tx_ready_o = ~hold_full.
  - A transfer happens when tx_valid_i && tx_ready_o; it sets hold_full.
- Byte load into tx_shift:
  - Happens on cs_fall, and on sck_fall when bit_cnt == 0 in ACTIVE.
  - Source is the holding register if hold_full, which is then cleared. Otherwise the source is TxIdleByte and tx_underrun_o pulses.
  - A byte that arrives on tx_valid_i in the same cycle as a load is taken into the holding register, not into the current load.
- Shifting:
  - spi_miso_o = tx_shift[7].
  - On sck_fall with bit_cnt != 0, tx_shift shifts left.
  - On sck_rise, rx_shift = {rx_shift[6:0], mosi_sync} and bit_cnt = bit_cnt + 1 (3 bits, wraps 7 → 0).
- Byte complete (sck_rise that wraps bit_cnt to 0):
  - If rx_valid_o == 0: rx_data_o ← the completed byte and rx_valid_o ← 1.
  - Otherwise the new byte is dropped, rx_data_o is unchanged and rx_overrun_o pulses.
  - rx_valid_o clears on rx_valid_o && rx_ready_i.
- Prefetch: the sck_fall after the 8th bit loads the next byte. The last load in a transaction therefore consumes a held byte even if the host never clocks it.
- Deselect (cs_rise):
  - spi_miso_en_o ← 0.
  - If bit_cnt != 0: abort_o pulses and the partial rx_shift is discarded.
  - bit_cnt ← 0.
  - The holding register and rx_valid_o are unaffected.
- Reset values: rx_data_o = 0, rx_valid_o = 0, tx_ready_o = 1 (holding register empty), spi_miso_o = 0, spi_miso_en_o = 0, active_o = 0, all pulse outputs 0. FSM is in IDLE with bit_cnt = 0.
- Reset asserted mid-transaction clears all state immediately. After reset release, activity only resumes on a fresh cs_fall; a CS already low at release is not treated as a select.

## Timing
- An event is flagged SyncStages+1 cycles after the pin transition is first sampled.
- spi_miso_o and spi_miso_en_o update 1 cycle after the event, i.e. SyncStages+2 cycles after the pin transition.
- rx_valid_o asserts 1 cycle after the 8th sck_rise event.
- Bus constraints: SCK high and low times ≥ SyncStages+4 clk_sys cycles, i.e. SCK ≤ clk_sys/12 for the default SyncStages = 2. CS_N to first SCK edge ≥ SyncStages+4 cycles.
- active_o follows the FSM: 1 in ACTIVE, registered.

## Test plan
1. Reset: assert rst_sys_i mid-byte with hold full → all outputs at their reset values in the same cycle; tx_ready_o = 1 after release.
2. Single byte: preload 0xA5, host sends 0x3C → MISO sampled by the host on rising edges = 1,0,1,0,0,1,0,1; rx_data_o = 0x3C with rx_valid_o high until rx_ready_i; no error pulses.
3. Back-to-back with underrun: preload 0x5A only, host clocks two bytes → host receives 0x5A then 0xFF; tx_underrun_o pulses exactly once.
4. Overrun: rx_ready_i held 0, host sends 0x11 then 0x22 → rx_data_o stays 0x11; rx_overrun_o pulses once, 1 cycle after the 16th sck_rise event.
5. Abort: CS deasserted after 5 SCK bits → abort_o pulses once and rx_valid_o stays 0. A following transaction with host sending 0x80 → rx_data_o = 0x80.
6. Same-cycle load/accept: drive tx_valid_i with 0x77 in the exact cycle of the cs_fall load with hold empty → TxIdleByte is shifted, tx_underrun_o pulses, and 0x77 is held and sent as the next byte.

Source files
------------

// File: rtl/spi_target.sv
// SPI target (mode 0, MSB first, 8-bit frames) oversampled in the system clock domain.
// Received bytes leave on a valid/ready stream; bytes to send arrive on a second one
// through a single-entry holding register.
module spi_target #(
  parameter int unsigned SyncStages = 2,
  parameter logic [7:0]  TxIdleByte = 8'hFF
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_en_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       active_o,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  output logic       abort_o
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  logic [SyncStages-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                  sck_prev_q, cs_prev_q;
  logic                  sck_s, cs_s, mosi_s;
  logic                  sck_rise, sck_fall, cs_fall, cs_rise;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_en_q, miso_en_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic       abort_q, abort_d;
  logic       load;

  // Input synchronisers plus one edge-detect flop per bus line.
  // The CS chain resets to 0 so a CS already low at reset release never looks like a select.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_ni};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SyncStages-1];
  assign cs_s     = cs_sync_q[SyncStages-1];
  assign mosi_s   = mosi_sync_q[SyncStages-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // State, shift, holding and stream registers.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_en_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_en_q   <= miso_en_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  // Next-state: select/deselect, bit shifting, byte completion, TX load and holding register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready_i;
    miso_en_d   = miso_en_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          miso_en_d = 1'b1;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect takes priority over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d    = IDLE;
          miso_en_d  = 1'b0;
          abort_d    = (bit_cnt_q != 3'd0);
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rx_valid_q) begin
              rx_data_d  = {rx_shift_q, mosi_s};
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = TxIdleByte;
        underrun_d = 1'b1;
      end
    end

    // A byte accepted in a load cycle goes to the holding register, not the current load.
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  assign spi_miso_o    = tx_shift_q[7];
  assign spi_miso_en_o = miso_en_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~hold_full_q;
  assign active_o      = (state_q == ACTIVE);
  assign rx_overrun_o  = overrun_q;
  assign tx_underrun_o = underrun_q;
  assign abort_o       = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bus-level SPI host model, table-driven single-byte
// transfers and hand-written multi-cycle sequences, with an RX scoreboard.
module tb_spi_target;

  logic       clk_sys_i = 1'b0;
  logic       rst_sys_i = 1'b1;
  logic       spi_sck_i = 1'b0;
  logic       spi_cs_ni = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o;
  logic       spi_miso_en_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic       active_o;
  logic       rx_overrun_o;
  logic       tx_underrun_o;
  logic       abort_o;

  spi_target #(.SyncStages(2), .TxIdleByte(8'hFF)) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_i    (rst_sys_i),
    .spi_sck_i    (spi_sck_i),
    .spi_cs_ni    (spi_cs_ni),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_en_o(spi_miso_en_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .active_o     (active_o),
    .rx_overrun_o (rx_overrun_o),
    .tx_underrun_o(tx_underrun_o),
    .abort_o      (abort_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int passed = 0;
  int total  = 0;

  // Monitor: collects accepted RX bytes and counts status pulses.
  logic [7:0] got_q[$];
  int under_cnt = 0;
  int over_cnt  = 0;
  int abort_cnt = 0;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk_sys_i) begin
    if (!rst_sys_i) begin
      if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
      if (tx_underrun_o) under_cnt++;
      if (rx_overrun_o)  over_cnt++;
      if (abort_o)       abort_cnt++;
    end
  end

  logic [7:0] exp_q[$];
  int got_rd = 0;

  typedef struct {
    bit         preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_under;
  } vec_t;

  vec_t vecs[5];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys_i);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready_o && n < 100) begin
      cyc(1);
      n++;
    end
    check("preload_ready_wait", {31'd0, tx_ready_o}, 32'd1);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    cyc(1);
    tx_valid_i = 1'b0;
    check("preload_held", {31'd0, tx_ready_o}, 32'd0);
  endtask

  // Mode-0 host: data changes while SCK low, target output sampled as SCK rises.
  // merge_end drops SCK and raises CS together so the trailing fall is not seen.
  task automatic host_txn(input int nbits, input logic [31:0] mbits, input bit merge_end,
                          output logic [31:0] sbits, output logic en_seen);
    sbits   = '0;
    en_seen = 1'b0;
    spi_cs_ni = 1'b0;
    cyc(10);
    for (int k = 0; k < nbits; k++) begin
      spi_mosi_i = mbits[nbits-1-k];
      cyc(8);
      spi_sck_i = 1'b1;
      sbits = {sbits[30:0], spi_miso_o};
      if (k == 0) en_seen = spi_miso_en_o;
      cyc(8);
      spi_sck_i = 1'b0;
      if (k == nbits - 1 && merge_end) spi_cs_ni = 1'b1;
    end
    if (!merge_end) begin
      cyc(8);
      spi_cs_ni = 1'b1;
    end
    cyc(12);
  endtask

  // Compare every expected RX byte against what the monitor collected.
  task automatic drain_rx(input string name);
    logic [7:0] e;
    int n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (got_rd >= got_q.size() && n < 200) begin
        cyc(1);
        n++;
      end
      if (got_rd < got_q.size()) begin
        check(name, {24'd0, got_q[got_rd]}, {24'd0, e});
        got_rd++;
      end else begin
        check({name, "_timeout"}, 32'd0, 32'd1);
      end
    end
    check({name, "_no_extra"}, got_q.size(), got_rd);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sb;
    logic en;
    int u0, o0, a0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{1'b0, 8'h00, 8'h7E, 8'hFF, 8'h7E, 1};
    vecs[4] = '{1'b1, 8'h81, 8'hC3, 8'h81, 8'hC3, 0};

    // Reset state
    cyc(3);
    check("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check("rst_miso", {31'd0, spi_miso_o}, 32'd0);
    check("rst_miso_en", {31'd0, spi_miso_en_o}, 32'd0);
    check("rst_active", {31'd0, active_o}, 32'd0);
    rst_sys_i = 1'b0;
    cyc(5);
    check("post_rst_active", {31'd0, active_o}, 32'd0);

    // Table of single-byte transfers
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].preload) preload(vecs[i].tx);
      u0 = under_cnt; o0 = over_cnt; a0 = abort_cnt;
      exp_q.push_back(vecs[i].exp_rx);
      host_txn(8, {24'd0, vecs[i].mosi}, 1'b1, sb, en);
      check("vec_miso", sb, {24'd0, vecs[i].exp_miso});
      check("vec_miso_en_during", {31'd0, en}, 32'd1);
      check("vec_miso_en_after", {31'd0, spi_miso_en_o}, 32'd0);
      check("vec_active_after", {31'd0, active_o}, 32'd0);
      check("vec_underrun", under_cnt - u0, vecs[i].exp_under);
      check("vec_overrun", over_cnt - o0, 0);
      check("vec_abort", abort_cnt - a0, 0);
      drain_rx("vec_rx");
    end

    // Back-to-back bytes with underrun on the prefetch
    preload(8'h5A);
    u0 = under_cnt; o0 = over_cnt;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    host_txn(16, 32'h1234, 1'b1, sb, en);
    check("b2b_miso", sb, 32'h5AFF);
    check("b2b_underrun", under_cnt - u0, 1);
    check("b2b_overrun", over_cnt - o0, 0);
    drain_rx("b2b_rx");

    // Overrun with consumer stalled
    rx_ready_i = 1'b0;
    u0 = under_cnt; o0 = over_cnt;
    host_txn(16, 32'h1122, 1'b1, sb, en);
    check("ovr_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    check("ovr_rx_data", {24'd0, rx_data_o}, 32'h11);
    check("ovr_pulses", over_cnt - o0, 1);
    check("ovr_underrun", under_cnt - u0, 2);
    exp_q.push_back(8'h11);
    rx_ready_i = 1'b1;
    cyc(2);
    check("ovr_rx_cleared", {31'd0, rx_valid_o}, 32'd0);
    drain_rx("ovr_rx");

    // Abort after 5 bits, then a clean byte
    a0 = abort_cnt;
    host_txn(5, 32'h15, 1'b0, sb, en);
    check("abort_pulse", abort_cnt - a0, 1);
    check("abort_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("abort_no_rx", got_q.size(), got_rd);
    exp_q.push_back(8'h80);
    host_txn(8, 32'h80, 1'b1, sb, en);
    check("abort_followup_pulse", abort_cnt - a0, 1);
    drain_rx("abort_rx");

    // TX byte offered in the exact cycle of the select load
    u0 = under_cnt;
    spi_cs_ni = 1'b0;
    cyc(2);
    tx_data_i  = 8'h77;
    tx_valid_i = 1'b1;
    cyc(1);
    tx_valid_i = 1'b0;
    check("same_cycle_held", {31'd0, tx_ready_o}, 32'd0);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hDE);
    host_txn(16, 32'hC0DE, 1'b1, sb, en);
    check("same_cycle_miso", sb, 32'hFF77);
    check("same_cycle_underrun", under_cnt - u0, 1);
    check("same_cycle_hold_empty", {31'd0, tx_ready_o}, 32'd1);
    drain_rx("same_cycle_rx");

    // Reset mid-byte with hold full and an unaccepted RX byte
    rx_ready_i = 1'b0;
    preload(8'h3C);
    host_txn(8, 32'h99, 1'b1, sb, en);
    preload(8'h44);
    spi_cs_ni = 1'b0;
    cyc(10);
    for (int k = 0; k < 2; k++) begin
      spi_mosi_i = 1'b1;
      cyc(8);
      spi_sck_i = 1'b1;
      cyc(8);
      spi_sck_i = 1'b0;
    end
    cyc(4);
    check("pre_rst_active", {31'd0, active_o}, 32'd1);
    check("pre_rst_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    check("pre_rst_rx_data", {24'd0, rx_data_o}, 32'h99);
    rst_sys_i = 1'b1;
    #1;
    check("midrst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data_o}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check("midrst_miso", {31'd0, spi_miso_o}, 32'd0);
    check("midrst_miso_en", {31'd0, spi_miso_en_o}, 32'd0);
    check("midrst_active", {31'd0, active_o}, 32'd0);
    cyc(3);
    rst_sys_i = 1'b0;
    cyc(20);
    check("cs_low_at_release_active", {31'd0, active_o}, 32'd0);
    check("cs_low_at_release_en", {31'd0, spi_miso_en_o}, 32'd0);
    check("release_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    spi_cs_ni = 1'b1;
    cyc(10);
    rx_ready_i = 1'b1;
    u0 = under_cnt;
    exp_q.push_back(8'h5E);
    host_txn(8, 32'h5E, 1'b1, sb, en);
    check("post_rst_miso", sb, 32'hFF);
    check("post_rst_underrun", under_cnt - u0, 1);
    drain_rx("post_rst_rx");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
